// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 TX path: word width, header magic,
// arbiter state encoding and the header-word builder.
package ft245_pkg;

    localparam int          FT245_WORD_W = 32;
    localparam logic [15:0] TX_HDR_MAGIC = 16'hA55A;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HDR   = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

    function automatic logic [FT245_WORD_W-1:0] tx_hdr_word(input logic [2:0] gid);
        return {TX_HDR_MAGIC, 13'd0, gid};
    endfunction

endpackage

// File: rtl/ft245_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first requester at or
// after ptr, wrapping at NUM_SRC-1.
module rr_select #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         grant_idx,
    output logic               grant_vld
);

    logic [3:0] cand_s;

    // Walk the sources in priority order starting at ptr; first hit wins
    always_comb begin
        grant_idx = 3'd0;
        grant_vld = 1'b0;
        cand_s    = 4'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_s = {1'b0, ptr} + 4'(k);
            if (cand_s >= 4'(NUM_SRC)) begin
                cand_s = cand_s - 4'(NUM_SRC);
            end else begin
                cand_s = cand_s;
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!grant_vld && req[j] && (cand_s == 4'(j))) begin
                    grant_vld = 1'b1;
                    grant_idx = 3'(j);
                end else begin
                    grant_vld = grant_vld;
                end
            end
        end
    end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: round-robin arbiter of NUM_SRC word streams into the
// core_ft245 TX port. Define FT245_TX_ARB_HEADER_EN to prefix every grant
// with the header word {16'hA55A, 13'd0, grant_id}.
module ft245_tx_arbiter
    import ft245_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_req,
    input  logic [32*NUM_SRC-1:0]       src_data,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_ack,
    input  logic                        tx_ready,
    output logic                        tx_write,
    output logic [FT245_WORD_W-1:0]     tx_data,
    output logic                        busy,
    output logic [2:0]                  grant_id
);

    localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);
    localparam logic [2:0]  LAST_SRC   = 3'(NUM_SRC - 1);

`ifdef FT245_TX_ARB_HEADER_EN
    localparam arb_state_e GRANT_ST = ARB_HDR;
`else
    localparam arb_state_e GRANT_ST = ARB_BURST;
`endif

    arb_state_e              state_q, state_d;
    logic [2:0]              rr_ptr_q, rr_ptr_d;
    logic [2:0]              gnt_q, gnt_d;
    logic [15:0]             cnt_q, cnt_d;

    logic [2:0]              sel_idx_s;
    logic                    sel_vld_s;
    logic                    g_req_s;
    logic                    g_last_s;
    logic [FT245_WORD_W-1:0] g_data_s;
    logic                    xfer_s;

    rr_select #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_select (
        .req       (src_req),
        .ptr       (rr_ptr_q),
        .grant_idx (sel_idx_s),
        .grant_vld (sel_vld_s)
    );

    // Mux the granted source's request, last flag and data onto one lane
    always_comb begin
        g_req_s  = 1'b0;
        g_last_s = 1'b0;
        g_data_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            g_req_s  = g_req_s  | (src_req[i]  & (gnt_q == 3'(i)));
            g_last_s = g_last_s | (src_last[i] & (gnt_q == 3'(i)));
            g_data_s = g_data_s | (src_data[FT245_WORD_W*i +: FT245_WORD_W]
                                   & {FT245_WORD_W{gnt_q == 3'(i)}});
        end
    end

    // Next-state logic; the TX handshake is combinational so a word moves
    // in the same cycle src_req and tx_ready meet. Reset low blocks writes.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        tx_write = 1'b0;
        tx_data  = '0;
        xfer_s   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (sel_vld_s) begin
                    gnt_d   = sel_idx_s;
                    cnt_d   = 16'd0;
                    state_d = GRANT_ST;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_HDR: begin
`ifdef FT245_TX_ARB_HEADER_EN
                if (rst && tx_ready) begin
                    tx_write = 1'b1;
                    tx_data  = tx_hdr_word(gnt_q);
                    state_d  = ARB_BURST;
                end else begin
                    state_d  = ARB_HDR;
                end
`else
                state_d = ARB_IDLE;
`endif
            end
            ARB_BURST: begin
                if (rst && g_req_s && tx_ready) begin
                    xfer_s   = 1'b1;
                    tx_write = 1'b1;
                    tx_data  = g_data_s;
                    cnt_d    = cnt_q + 16'd1;
                    if (g_last_s || (cnt_q == BURST_LAST)) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = (gnt_q == LAST_SRC) ? 3'd0 : (gnt_q + 3'd1);
                    end else begin
                        state_d  = ARB_BURST;
                    end
                end else begin
                    state_d = ARB_BURST;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Only the granted source sees its acknowledge
    always_comb begin
        src_ack = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ack[i] = xfer_s & (gnt_q == 3'(i));
        end
    end

    // State, round-robin pointer, grant index and payload counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= 3'd0;
            gnt_q    <= 3'd0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy     = (state_q != ARB_IDLE);
    assign grant_id = busy ? gnt_q : 3'd0;

endmodule

// File: doc/ft245_tx_arbiter.md
FT245_TX_ARBITER -- requirements
Module: ft245_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of TX requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 256, maximum payload words per grant (1..65535).
REQ-003 SHALL have port clk, input, 1, single clock, same domain as core_ft245 tx_clk.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port src_req, input, NUM_SRC, per-source "word available".
REQ-006 SHALL have port src_data, input, 32*NUM_SRC, per-source word; source i occupies bits [32i+31:32i].
REQ-007 SHALL have port src_last, input, NUM_SRC, per-source "current word ends packet".
REQ-008 SHALL have port src_ack, output, NUM_SRC, per-source "word consumed this cycle".
REQ-009 SHALL have port tx_ready, input, 1, core TX FIFO can accept a word this cycle.
REQ-010 SHALL have port tx_write, output, 1, write strobe into core_ft245 tx_write.
REQ-011 SHALL have port tx_data, output, 32, word into core_ft245 tx_data.
REQ-012 SHALL have port busy, output, 1, a grant is active.
REQ-013 SHALL have port grant_id, output, 3, index of granted source; valid while busy.

Function
REQ-014 SHALL implement states IDLE, HDR, BURST.
REQ-015 In IDLE with any src_req high, SHALL grant the first requesting source at or after rr_ptr (wrapping) on the next clock edge; next state HDR if header enabled, else BURST.
REQ-016 SHALL leave IDLE with src_req all-zero unchanged: no grant, all outputs 0.
REQ-017 In BURST, tx_write and src_ack[grant_id] SHALL both be combinationally src_req[grant_id] && tx_ready; other src_ack bits 0; zero-cycle latency.
REQ-018 tx_data SHALL equal the granted source's src_data whenever tx_write is high; 0 otherwise.
REQ-019 Payload counter (16 bit) SHALL increment per transferred word and clear on grant.
REQ-020 Grant SHALL end after the transfer of a word with src_last high, or after the MAX_BURST-th word, whichever comes first; next state IDLE.
REQ-021 On grant end, rr_ptr SHALL become grant_id+1, wrapping NUM_SRC-1 to 0.
REQ-022 src_req low or tx_ready low in BURST SHALL stall with grant, counter and state held; no timeout.
REQ-023 busy SHALL be high in HDR and BURST, low in IDLE.
REQ-024 Simultaneous requests SHALL be served strictly round-robin; no source waits more than NUM_SRC-1 grants.
REQ-025 Changes to src_req of non-granted sources during a grant SHALL have no effect until IDLE.

Reset
REQ-026 With rst low at a clock edge: state IDLE, rr_ptr 0, counter 0, grant_id 0, busy 0, tx_write 0, tx_data 0, src_ack 0.
REQ-027 Reset mid-HDR or mid-BURST SHALL abandon the grant without emitting further words; the partial packet is not completed.

Configuration
REQ-028 Macro FT245_TX_ARB_HEADER_EN SHALL, when defined, enable state HDR: one header word {16'hA55A, 13'd0, grant_id} is written when tx_ready is high (tx_write 1, no src_ack), then BURST.
REQ-029 Without FT245_TX_ARB_HEADER_EN, HDR SHALL be absent and output bit-identical to passing only payload words.

Structure
REQ-030 Package ft245_pkg SHALL hold FT245_WORD_W=32, TX_HDR_MAGIC=16'hA55A and the arbiter state enum.
REQ-031 Round-robin selection SHALL be a sub-module rr_select (request vector + pointer -> one-hot/index, combinational).

Verification
REQ-032 Single source 0, 3 words, last on word 3, tx_ready=1 -> tx_data sequence equals inputs, busy low one cycle after word 3, rr_ptr=1.
REQ-033 All four src_req high, each 1-word packet -> grant order 0,1,2,3,0; with header enabled each payload is preceded by 0xA55A000i.
REQ-034 MAX_BURST=4, source 2 streams 10 words without last -> grant released after 4 words, source 3 granted if requesting, else source 2 again.
REQ-035 tx_ready toggled 1,0,0,1 mid-burst -> tx_write/src_ack low for exactly two cycles, no word lost or duplicated.
REQ-036 rst low during word 2 of 5 -> next cycle all outputs 0, state IDLE; next grant goes to source 0.
